// File: rtl/stopwatch_ctrl.sv
// Run/pause/lap/clear sequencer for a centisecond/second/minute stopwatch chain.
// Converts debounced button pulses and the 10 ms tick into counter, clear and display-hold controls.
module stopwatch_ctrl #(
    parameter int HOLD_TICKS   = 300,
    parameter int MAX_LAPS     = 15,
    parameter int LAP_W        = 4,
    parameter bit STOP_ON_WRAP = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start_stop,
    input  logic             lap,
    input  logic             clear,
    input  logic             tick,
    input  logic             at_max,
    output logic             timer_en,
    output logic             count_en,
    output logic             count_clr,
    output logic             snap_load,
    output logic             disp_hold,
    output logic [LAP_W-1:0] lap_num,
    output logic [1:0]       state
);

    localparam int HOLD_W = $clog2(HOLD_TICKS + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        LAP   = 2'b10,
        PAUSE = 2'b11
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [LAP_W-1:0]   r_lap_num;
    logic [LAP_W-1:0]   w_lap_num_nxt;
    logic [LAP_W-1:0]   w_lap_num_inc;
    logic [HOLD_W-1:0]  r_hold;
    logic [HOLD_W-1:0]  w_hold_nxt;
    logic               r_count_clr;
    logic               w_count_clr_nxt;
    logic               r_snap_load;
    logic               w_snap_load_nxt;
    logic               w_timer_en;
    logic               w_wrap_stop;

    // A tick arriving at 59:59.99 must pause the chain instead of counting past it.
    assign w_wrap_stop   = STOP_ON_WRAP & tick & at_max;
    assign w_lap_num_inc = (r_lap_num < LAP_W'(MAX_LAPS)) ? r_lap_num + 1'b1 : r_lap_num;
    assign w_timer_en    = (r_state == RUN) || (r_state == LAP);

    // NOTE: every signal written below gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_state_nxt     = r_state;
        w_lap_num_nxt   = r_lap_num;
        w_hold_nxt      = r_hold;
        w_count_clr_nxt = 1'b0;
        w_snap_load_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (clear) begin
                    w_count_clr_nxt = 1'b1;
                    w_lap_num_nxt   = '0;
                end else if (start_stop) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (start_stop || w_wrap_stop) begin
                    w_state_nxt = PAUSE;
                end else if (lap) begin
                    w_state_nxt     = LAP;
                    w_snap_load_nxt = 1'b1;
                    w_hold_nxt      = HOLD_W'(HOLD_TICKS);
                    w_lap_num_nxt   = w_lap_num_inc;
                end
            end
            LAP: begin
                if (start_stop || w_wrap_stop) begin
                    w_state_nxt = PAUSE;
                    w_hold_nxt  = '0;
                end else if (lap) begin
                    w_snap_load_nxt = 1'b1;
                    w_hold_nxt      = HOLD_W'(HOLD_TICKS);
                    w_lap_num_nxt   = w_lap_num_inc;
                end else if (tick) begin
                    if (r_hold <= HOLD_W'(1)) begin
                        w_state_nxt = RUN;
                        w_hold_nxt  = '0;
                    end else begin
                        w_hold_nxt = r_hold - 1'b1;
                    end
                end
            end
            PAUSE: begin
                if (clear) begin
                    w_state_nxt     = IDLE;
                    w_count_clr_nxt = 1'b1;
                    w_lap_num_nxt   = '0;
                end else if (start_stop) begin
                    w_state_nxt = RUN;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments and an asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lap_num   <= '0;
            r_hold      <= '0;
            r_count_clr <= 1'b0;
            r_snap_load <= 1'b0;
        end else begin
            r_lap_num   <= w_lap_num_nxt;
            r_hold      <= w_hold_nxt;
            r_count_clr <= w_count_clr_nxt;
            r_snap_load <= w_snap_load_nxt;
        end
    end

    assign timer_en  = w_timer_en;
    assign count_en  = tick & w_timer_en & ~(STOP_ON_WRAP & at_max);
    assign count_clr = r_count_clr;
    assign snap_load = r_snap_load;
    assign disp_hold = (r_state == LAP);
    assign lap_num   = r_lap_num;
    assign state     = r_state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: directed scenarios plus randomized pulses
// compared cycle by cycle against a behavioural stopwatch model.
module tb_stopwatch_ctrl;

    localparam int HOLD = 3;
    localparam int MAXL = 15;
    localparam int LW   = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start_stop = 1'b0;
    logic          lap = 1'b0;
    logic          clear = 1'b0;
    logic          tick = 1'b0;
    logic          at_max = 1'b0;
    logic          timer_en;
    logic          count_en;
    logic          count_clr;
    logic          snap_load;
    logic          disp_hold;
    logic [LW-1:0] lap_num;
    logic [1:0]    state;

    stopwatch_ctrl #(
        .HOLD_TICKS  (HOLD),
        .MAX_LAPS    (MAXL),
        .LAP_W       (LW),
        .STOP_ON_WRAP(1'b1)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start_stop(start_stop),
        .lap       (lap),
        .clear     (clear),
        .tick      (tick),
        .at_max    (at_max),
        .timer_en  (timer_en),
        .count_en  (count_en),
        .count_clr (count_clr),
        .snap_load (snap_load),
        .disp_hold (disp_hold),
        .lap_num   (lap_num),
        .state     (state)
    );

    always #5 clk = ~clk;

    // {state, timer_en, count_en, count_clr, snap_load, disp_hold, lap_num}
    logic [10:0] w_obs;
    assign w_obs = {state, timer_en, count_en, count_clr, snap_load, disp_hold, lap_num};

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: the watch is idle (cleared), paused, or running;
    // while running it may be showing a lap for a number of remaining ticks.
    bit          m_idle;
    bit          m_running;
    bit          m_showing;
    int          m_ticks_left;
    int          m_laps;
    bit          m_clr_pulse;
    bit          m_snap_pulse;
    bit          g_pending;
    logic [10:0] g_exp;

    task automatic model_reset();
        m_idle       = 1'b1;
        m_running    = 1'b0;
        m_showing    = 1'b0;
        m_ticks_left = 0;
        m_laps       = 0;
        m_clr_pulse  = 1'b0;
        m_snap_pulse = 1'b0;
        g_pending    = 1'b0;
    endtask

    task automatic model_update(input bit ss, input bit lp, input bit cl, input bit tk, input bit am);
        m_clr_pulse  = 1'b0;
        m_snap_pulse = 1'b0;
        if (m_idle) begin
            if (cl) begin
                m_clr_pulse = 1'b1;
                m_laps      = 0;
            end else if (ss) begin
                m_idle    = 1'b0;
                m_running = 1'b1;
            end
        end else if (!m_running) begin
            if (cl) begin
                m_idle      = 1'b1;
                m_clr_pulse = 1'b1;
                m_laps      = 0;
            end else if (ss) begin
                m_running = 1'b1;
            end
        end else begin
            if (ss || (tk && am)) begin
                m_running = 1'b0;
                m_showing = 1'b0;
            end else if (lp) begin
                m_showing    = 1'b1;
                m_ticks_left = HOLD;
                m_snap_pulse = 1'b1;
                if (m_laps < MAXL) m_laps = m_laps + 1;
            end else if (m_showing && tk) begin
                m_ticks_left = m_ticks_left - 1;
                if (m_ticks_left == 0) m_showing = 1'b0;
            end
        end
    endtask

    function automatic logic [10:0] expect_vec(input bit tk, input bit am);
        logic [1:0]    st;
        logic [LW-1:0] ln;
        if (m_idle)          st = 2'b00;
        else if (!m_running) st = 2'b11;
        else if (m_showing)  st = 2'b10;
        else                 st = 2'b01;
        ln = LW'(m_laps);
        return {st, m_running, tk && m_running && !am, m_clr_pulse, m_snap_pulse, m_showing, ln};
    endfunction

    // Advance the model past the upcoming edge, then apply new inputs mid-cycle.
    task automatic drive(input bit ss, input bit lp, input bit cl, input bit tk, input bit am);
        if (g_pending) model_update(start_stop, lap, clear, tick, at_max);
        @(negedge clk);
        start_stop = ss;
        lap        = lp;
        clear      = cl;
        tick       = tk;
        at_max     = am;
        g_pending  = 1'b1;
        #1;
        g_exp = expect_vec(tk, am);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset_n    = 1'b0;
        start_stop = 1'b0;
        lap        = 1'b0;
        clear      = 1'b0;
        tick       = 1'b0;
        at_max     = 1'b0;
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset_n = 1'b0;
        tick    = 1'b1;
        model_reset();
        #1;
        n_tests++;
        if (w_obs !== 11'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want %b", w_obs, 11'b0);
        end
        tick = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_run_count();
        int pulses = 0;
        apply_reset();
        drive(1, 0, 0, 0, 0);
        n_tests++;
        if (w_obs !== g_exp) begin
            n_fail++;
            $display("FAIL run_start: got %b want %b", w_obs, g_exp);
        end
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 1, 0);
            if (count_en === 1'b1) pulses++;
            n_tests++;
            if (w_obs !== g_exp) begin
                n_fail++;
                $display("FAIL run_tick%0d: got %b want %b", i, w_obs, g_exp);
            end
        end
        n_tests++;
        if (pulses !== 5 || state !== 2'b01 || timer_en !== 1'b1) begin
            n_fail++;
            $display("FAIL run_count: got pulses=%0d state=%b want pulses=5 state=01", pulses, state);
        end
    endtask

    task automatic test_lap_hold();
        int held_ticks = 0;
        apply_reset();
        drive(1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 0, i[0], 0);
            if (disp_hold === 1'b1 && tick) held_ticks++;
            n_tests++;
            if (w_obs !== g_exp) begin
                n_fail++;
                $display("FAIL lap_hold_cyc%0d: got %b want %b", i, w_obs, g_exp);
            end
        end
        n_tests++;
        if (held_ticks !== HOLD || state !== 2'b01 || lap_num !== 4'd1) begin
            n_fail++;
            $display("FAIL lap_hold_len: got ticks=%0d state=%b laps=%0d want ticks=%0d state=01 laps=1",
                     held_ticks, state, lap_num, HOLD);
        end
    endtask

    task automatic test_clear();
        apply_reset();
        drive(1, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0);
        drive(0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0);
        n_tests++;
        if (w_obs !== g_exp || count_clr !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_ignored_run: got %b want %b", w_obs, g_exp);
        end
        drive(1, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0);
        n_tests++;
        if (w_obs !== g_exp || count_clr !== 1'b1 || lap_num !== '0 || state !== 2'b00) begin
            n_fail++;
            $display("FAIL clear_from_pause: got %b want %b", w_obs, g_exp);
        end
        drive(0, 0, 0, 0, 0);
        n_tests++;
        if (w_obs !== g_exp || count_clr !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_one_cycle: got %b want %b", w_obs, g_exp);
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        drive(1, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 1);
        n_tests++;
        if (w_obs !== g_exp || count_en !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_tick: got %b want %b", w_obs, g_exp);
        end
        drive(0, 0, 0, 0, 1);
        n_tests++;
        if (w_obs !== g_exp || state !== 2'b11 || timer_en !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_pause: got %b want %b", w_obs, g_exp);
        end
        drive(1, 0, 0, 0, 1);
        drive(0, 0, 0, 1, 1);
        drive(0, 0, 0, 0, 1);
        n_tests++;
        if (w_obs !== g_exp || state !== 2'b11) begin
            n_fail++;
            $display("FAIL wrap_resume: got %b want %b", w_obs, g_exp);
        end
    endtask

    task automatic test_lap_saturate();
        int snaps = 0;
        apply_reset();
        drive(1, 0, 0, 0, 0);
        for (int i = 0; i < 17; i++) begin
            drive(0, 1, 0, 0, 0);
            drive(0, 0, 0, (i % 3) == 0, 0);
            if (snap_load === 1'b1) snaps++;
            n_tests++;
            if (w_obs !== g_exp) begin
                n_fail++;
                $display("FAIL lap_sat%0d: got %b want %b", i, w_obs, g_exp);
            end
        end
        n_tests++;
        if (snaps !== 17 || lap_num !== 4'd15) begin
            n_fail++;
            $display("FAIL lap_sat_final: got snaps=%0d laps=%0d want snaps=17 laps=15", snaps, lap_num);
        end
    endtask

    task automatic test_priority();
        apply_reset();
        drive(1, 1, 1, 0, 0);
        drive(0, 0, 0, 0, 0);
        n_tests++;
        if (w_obs !== g_exp || state !== 2'b00 || count_clr !== 1'b1) begin
            n_fail++;
            $display("FAIL prio_idle: got %b want %b", w_obs, g_exp);
        end
        drive(1, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0);
        drive(1, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0);
        n_tests++;
        if (w_obs !== g_exp || state !== 2'b00) begin
            n_fail++;
            $display("FAIL prio_pause: got %b want %b", w_obs, g_exp);
        end
    endtask

    task automatic test_random();
        bit am = 1'b0;
        apply_reset();
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(39) == 0) am = ~am;
            drive($urandom_range(11) == 0, $urandom_range(5) == 0, $urandom_range(7) == 0,
                  $urandom_range(2) == 0, am);
            n_tests++;
            if (w_obs !== g_exp) begin
                n_fail++;
                $display("FAIL random_cyc%0d: got %b want %b", i, w_obs, g_exp);
            end
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        drive(1, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0);
        drive(0, 0, 0, 1, 0);
        n_tests++;
        if (w_obs !== g_exp || state !== 2'b10) begin
            n_fail++;
            $display("FAIL async_setup: got %b want %b", w_obs, g_exp);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_tests++;
        if (w_obs !== {2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0}) begin
            n_fail++;
            $display("FAIL async_reset_midcycle: got %b want %b", w_obs, 11'b0);
        end
        start_stop = 1'b0;
        lap        = 1'b0;
        clear      = 1'b0;
        tick       = 1'b0;
        at_max     = 1'b0;
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        drive(0, 0, 0, 0, 0);
        n_tests++;
        if (w_obs !== g_exp) begin
            n_fail++;
            $display("FAIL async_after_release: got %b want %b", w_obs, g_exp);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_run_count();
        test_lap_hold();
        test_clear();
        test_wrap();
        test_lap_saturate();
        test_priority();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
